// File: rtl/hilo_mdu_controller.sv
// hilo_mdu_controller
//   Multi-cycle multiply/divide sequencer that owns the HI/LO register pair.
//   Multiplication is unsigned shift-add, one multiplier bit per cycle.
//   Division is restoring, one quotient bit per cycle. Signed operations run
//   on magnitudes and the sign is fixed up in a single FIN cycle, which also
//   commits HI/LO.
//
// Ports
//   Clk       rising-edge clock
//   Reset     asynchronous active-high reset
//   Start     issue strobe for MduOp (accepted only while idle)
//   MduOp     000 mult, 001 multu, 010 madd, 011 msub,
//             100 div,  101 divu,  110 mthi, 111 mtlo
//   A, B      rs / rt operands
//   HiLoRead  mfhi/mflo present in decode
//   Busy      sequencer not idle
//   Stall     Busy & (HiLoRead | Start)
//   Done      one-cycle pulse after a mult/div-class commit
//   DivZero   one-cycle pulse alongside Done when the divisor was zero
//   Hi, Lo    architectural HI/LO registers
module hilo_mdu_controller #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MduOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiLoRead,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIN  = 2'b11
    } state_t;

    // Magnitude of a two's-complement word; the most negative value maps to
    // itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if_w(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if_d(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits shifting out / quotient bits in}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               sgn_q, sgn_d;
    logic               rsgn_q, rsgn_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_cand;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        sgn_d     = sgn_q;
        rsgn_d    = rsgn_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        div_cand = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = div_cand >= {1'b0, opb_q};
        // Only consumed when div_ge, where the true difference fits in WIDTH bits.
        div_diff = div_cand[WIDTH-1:0] - opb_q;
        product  = neg_if_d(sgn_q, acc_q);
        quo      = neg_if_w(sgn_q, acc_q[WIDTH-1:0]);
        rem      = neg_if_w(rsgn_q, acc_q[2*WIDTH-1:WIDTH]);

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d   = MduOp;
                    cnt_d  = '0;
                    dz_d   = 1'b0;
                    sgn_d  = 1'b0;
                    rsgn_d = 1'b0;
                    case (MduOp)
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        OP_MULTU: begin
                            acc_d   = {{WIDTH{1'b0}}, A};
                            opb_d   = B;
                            state_d = S_MUL;
                        end
                        OP_DIVU: begin
                            acc_d   = {{WIDTH{1'b0}}, A};
                            opb_d   = B;
                            dz_d    = (B == '0);
                            state_d = (B == '0) ? S_FIN : S_DIV;
                        end
                        OP_DIV: begin
                            acc_d   = {{WIDTH{1'b0}}, abs_w(A)};
                            opb_d   = abs_w(B);
                            sgn_d   = A[WIDTH-1] ^ B[WIDTH-1];
                            rsgn_d  = A[WIDTH-1];
                            dz_d    = (B == '0);
                            state_d = (B == '0) ? S_FIN : S_DIV;
                        end
                        default: begin
                            // mult, madd, msub share the signed-magnitude setup
                            acc_d   = {{WIDTH{1'b0}}, abs_w(A)};
                            opb_d   = abs_w(B);
                            sgn_d   = A[WIDTH-1] ^ B[WIDTH-1];
                            state_d = S_MUL;
                        end
                    endcase
                end
            end

            S_MUL: begin
                // Add multiplicand when the current multiplier bit is set, then
                // shift the whole accumulator right; the carry lands in the top bit.
                acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                 : {1'b0, acc_q[2*WIDTH-1:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) state_d = S_FIN;
            end

            S_DIV: begin
                acc_d = div_ge ? {div_diff,            acc_q[WIDTH-2:0], 1'b1}
                               : {div_cand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) state_d = S_FIN;
            end

            S_FIN: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                done_d    = 1'b1;
                divzero_d = dz_q;
                if (!dz_q) begin
                    case (op_q)
                        OP_MULT, OP_MULTU: {hi_d, lo_d} = product;
                        OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + product;
                        OP_MSUB:           {hi_d, lo_d} = {hi_q, lo_q} - product;
                        OP_DIV, OP_DIVU: begin
                            lo_d = quo;
                            hi_d = rem;
                        end
                        default: ;
                    endcase
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            sgn_q     <= 1'b0;
            rsgn_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            sgn_q     <= sgn_d;
            rsgn_q    <= rsgn_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign Busy    = (state_q != S_IDLE);
    assign Stall   = Busy & (HiLoRead | Start);
    assign Done    = done_q;
    assign DivZero = divzero_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule
